// File: rtl/noc_router_input_port.sv
// Router input port: frames NI flits into 6-flit packets, buffers them in a FWFT FIFO
// and presents each packet to one XY-routed crossbar output. Optional macro: NOC_PORT_ERR_CNT_EN.
module noc_router_input_port #(
    parameter logic [1:0] NODE_ID    = 2'b00,
    parameter int         DEPTH      = 8,
    parameter logic [5:0] HEADER_TAG = 6'b111111,
    parameter logic [7:0] TAIL_FLIT  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_flit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_flit,
    output logic [4:0] out_req,
    input  logic [4:0] out_ready,
    output logic       out_head,
    output logic       out_tail,
    output logic [7:0] err_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {TAG_BODY = 2'd0, TAG_HEAD = 2'd1, TAG_TAIL = 2'd2} tag_e;
    typedef enum logic [1:0] {IN_HEAD, IN_BODY, IN_TAIL} in_state_e;
    typedef enum logic {OUT_ROUTE, OUT_SEND} out_state_e;

    in_state_e  in_state_q;
    out_state_e out_state_q;
    logic [2:0] pos_q;
    logic [4:0] route_q;
    logic       rdy_q;

    logic [9:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        empty, full, push, pop, in_xfer, hdr_ok, send_vld;
    tag_e        push_tag;
    logic [9:0]  head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = rdy_q && !full;
    assign in_xfer  = in_valid && in_ready;
    assign hdr_ok   = (in_flit[7:2] == HEADER_TAG);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push     = 1'b0;
        push_tag = TAG_BODY;
        case (in_state_q)
            IN_HEAD: begin
                push     = in_xfer && hdr_ok;
                push_tag = TAG_HEAD;
            end
            IN_BODY: push = in_xfer;
            IN_TAIL: begin
                push     = in_xfer;
                push_tag = TAG_TAIL;
            end
            default: push = 1'b0;
        endcase
    end

    assign send_vld = (out_state_q == OUT_SEND) && !empty;
    assign out_req  = send_vld ? route_q : 5'b0;
    assign pop      = |(out_req & out_ready);
    assign out_flit = head[7:0];
    assign out_head = send_vld && (head[9:8] == TAG_HEAD);
    assign out_tail = send_vld && (head[9:8] == TAG_TAIL);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    // XY routing: resolve x first, then y; one-hot {S,N,W,E,L}.
    function automatic logic [4:0] xy_route(input logic [1:0] dest);
        if (dest[0] > NODE_ID[0])      return 5'b00010;
        else if (dest[0] < NODE_ID[0]) return 5'b00100;
        else if (dest[1] > NODE_ID[1]) return 5'b01000;
        else if (dest[1] < NODE_ID[1]) return 5'b10000;
        else                           return 5'b00001;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {push_tag, in_flit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q <= IN_HEAD;
            pos_q      <= 3'd0;
        end else if (in_xfer) begin
            case (in_state_q)
                IN_HEAD: if (hdr_ok) begin
                    in_state_q <= IN_BODY;
                    pos_q      <= 3'd1;
                end
                IN_BODY: begin
                    pos_q <= pos_q + 3'd1;
                    if (pos_q == 3'd4) in_state_q <= IN_TAIL;
                end
                default: begin
                    in_state_q <= IN_HEAD;
                    pos_q      <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= OUT_ROUTE;
            route_q     <= 5'b0;
        end else begin
            case (out_state_q)
                OUT_ROUTE: if (!empty) begin
                    route_q     <= xy_route(head[1:0]);
                    out_state_q <= OUT_SEND;
                end
                default: if (pop && head[9:8] == TAG_TAIL) out_state_q <= OUT_ROUTE;
            endcase
        end
    end

`ifdef NOC_PORT_ERR_CNT_EN
    logic [7:0] err_q;
    logic       err_evt;
    assign err_evt = in_xfer && (((in_state_q == IN_HEAD) && !hdr_ok) ||
                                 ((in_state_q == IN_TAIL) && (in_flit != TAIL_FLIT)));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_q <= 8'h00;
        else if (err_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: doc/noc_router_input_port.md
Name: noc_router_input_port

Overview:
- Router-side endpoint of the NI flit link; one instance per router input.
- Accepts 8-bit flits with a valid/ready handshake and frames them into 6-flit packets: header {6'b111111, dest[1:0]}, 4 data flits, tail 8'hFF.
- Buffers flits in a FIFO and computes an XY route for a 2x2 mesh from the header.
- Presents the packet, flit by flit, to exactly one crossbar output.

Parameters:
- NODE_ID, 2'b00, this router's address {y,x}.
- DEPTH, 8, FIFO depth in flits; power of 2, minimum 2.
- HEADER_TAG, 6'b111111, required value of header bits [7:2].
- TAIL_FLIT, 8'hFF, expected tail flit value.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_flit  in  8  flit from NI/upstream.
- in_valid  in  1  in_flit is valid.
- in_ready  out  1  port can accept a flit; equals !fifo_full.
- out_flit  out  8  FIFO head flit to crossbar.
- out_req  out  5  one-hot output request, bit order {S,N,W,E,L} = [4:0].
- out_ready  in  5  per-output accept from crossbar/arbiter.
- out_head  out  1  current out_flit is a header.
- out_tail  out  1  current out_flit is a tail.
- err_count  out  8  framing error count (see Optional Feature).

Behaviour:
- Reset values: in_ready=0 while rst_n low, 1 on the first cycle after release. out_req=0, out_head=0, out_tail=0, err_count=0, FIFO empty, both FSMs idle.
- Input transfer occurs when in_valid && in_ready.
- Input framing FSM, one transition per transfer:
  - IN_HEAD:
    - in_flit[7:2]==HEADER_TAG: push the flit tagged HEAD; pos=1; go to IN_BODY.
    - Otherwise: drop the flit (accepted, not pushed), count an error, stay in IN_HEAD.
  - IN_BODY: push tagged BODY; pos++. When pos reaches 5 (4 body flits pushed), go to IN_TAIL.
  - IN_TAIL: push tagged TAIL regardless of value; go to IN_HEAD.
    - in_flit!=TAIL_FLIT: count an error; the packet still terminates.
- FIFO:
  - DEPTH entries of {tag[1:0], flit[7:0]}, first-word-fall-through.
  - Pointers wrap modulo DEPTH; full/empty are tracked with an extra pointer bit.
  - Simultaneous push and pop is legal at any fill level except that push is blocked when full; there is no bypass.
- Output FSM:
  - OUT_ROUTE:
    - Wait for a non-empty FIFO; the head entry is always tagged HEAD.
    - Latch route from dest=flit[1:0] vs NODE_ID, XY order:
      - dest.x > my.x: E; dest.x < my.x: W.
      - Else dest.y > my.y: N; dest.y < my.y: S.
      - Else L.
    - Go to OUT_SEND next cycle.
  - OUT_SEND:
    - out_req = route one-hot while the FIFO is non-empty, else 0.
    - out_flit, out_head, out_tail reflect the FIFO head.
    - A transfer (out_req & out_ready nonzero) pops one entry.
    - Popping a TAIL returns to OUT_ROUTE; out_req drops the next cycle.
- The route is held for the whole packet. out_ready bits of unselected outputs are ignored.
- Latency: a header accepted at edge t appears with out_req valid in cycle t+2. Body flits stream at 1 flit/cycle when out_ready is held high.
- Reset mid-packet: FIFO flushed, route cleared, both FSMs return to HEAD/ROUTE. The next accepted flit must be a header.
- Minimum inter-packet gap at the output: 1 cycle (the OUT_ROUTE cycle).

Optional Feature:
- Macro NOC_PORT_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 on each dropped bad header and each bad tail.
  - Saturates at 8'hFF.
  - Both errors in one cycle are impossible; one transfer per cycle.
- Undefined: err_count is tied to 8'h00, no counter logic exists, framing behaviour is unchanged.

Test Plan:
- NODE_ID=00, send FD,12,34,56,78,FF with out_ready=5'b11111 -> out_req=5'b00010 (E) for 6 cycles starting 2 cycles after the header; flits in order; out_head on FD, out_tail on FF; then out_req=0.
- NODE_ID=00, header FC (dest 00) -> out_req=5'b00001 (L). Header FE (dest 10) -> out_req=5'b01000 (N). NODE_ID=11, header FC -> W first (5'b00100).
- Send 5A, then a valid packet FD..FF (macro on) -> 5A never appears at out_flit, err_count=1, packet routed E intact.
- Packet with tail 00 (macro on) -> 6 flits forwarded, out_tail on 00, err_count=1, next header framed correctly.
- DEPTH=8, out_ready=0, stream 10 flits -> in_ready low after 8 accepted. Raise out_ready -> in_ready returns 1 cycle after the first pop; all flits delivered in order.
- Deassert rst_n after 3 flits of a packet -> out_req=0 and FIFO empty immediately. After release, FD,.. is framed as a new header.
